// File: rtl/hud_text_ram.sv
// hud_text_ram: character RAM for the HUD text row. The host writes label text
// through the write port and the renderer reads through a registered port. An
// internal formatter converts each live numeric field (double-dabble) and writes
// its ASCII digits into that field's fixed slot.
module hud_text_ram #(
    parameter int                           DEPTH      = 160,
    parameter int                           ADDR_W     = 8,
    parameter int                           NUM_FIELDS = 2,
    parameter int                           VAL_W      = 10,
    parameter int                           DIGITS     = 3,
    parameter logic [NUM_FIELDS*ADDR_W-1:0] FIELD_BASE = {8'd32, 8'd7},
    parameter bit                           BLANK_LZ   = 1'b0
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NUM_FIELDS*VAL_W-1:0] values,
    input  logic [7:0]                  data_In,
    input  logic [ADDR_W-1:0]           write_address,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           read_address,
    output logic [7:0]                  data_Out,
    output logic                        busy,
    output logic                        update_done
);
    localparam int BCD_W   = DIGITS * 4;
    localparam int FW      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int CW      = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int KW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int MAX_VAL = 10**DIGITS - 1;
    localparam logic [VAL_W-1:0] SAT_VAL = VAL_W'(MAX_VAL);

    typedef enum logic [1:0] {IDLE, LOAD, CONVERT, WRITE} state_t;

    // Power-up image: blank row, with every digit slot pre-filled with '0'.
    function automatic logic [DEPTH-1:0][7:0] mem_init();
        logic [DEPTH-1:0][7:0] m;
        logic [ADDR_W-1:0]     a;
        m = '0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            for (int d = 0; d < DIGITS; d++) begin
                a = FIELD_BASE[f*ADDR_W +: ADDR_W] + ADDR_W'(d);
                if (int'(FIELD_BASE[f*ADDR_W +: ADDR_W]) + d < DEPTH)
                    m[a] = 8'h30;
            end
        end
        return m;
    endfunction

    // Next field in round-robin order, wrapping at NUM_FIELDS.
    function automatic logic [FW-1:0] rr_idx(input logic [FW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_FIELDS) s = s - NUM_FIELDS;
        return FW'(s);
    endfunction

    logic [DEPTH-1:0][7:0] mem = mem_init();

    state_t                             state, state_nx;
    logic [NUM_FIELDS-1:0]              dirty, pend;
    logic [NUM_FIELDS-1:0][VAL_W-1:0]   shadow;
    logic [FW-1:0]                      sel, rr, pick;
    logic                               any_pend;
    logic [VAL_W-1:0]                   bin, cur_val;
    logic [BCD_W-1:0]                   bcd, bcd_adj;
    logic [CW-1:0]                      cnt;
    logic [KW-1:0]                      k;
    logic                               seen_nz, last_digit, blank;
    logic [3:0]                         nib;
    logic [7:0]                         digit_char;
    logic [ADDR_W-1:0]                  field_base, fmt_addr;
    logic                               wr_en;
    logic [ADDR_W-1:0]                  wr_addr;
    logic [7:0]                         wr_data;

    // A field needs refreshing if flagged or if its live value differs from the last one converted.
    always_comb begin
        pend = '0;
        for (int f = 0; f < NUM_FIELDS; f++)
            pend[f] = dirty[f] | (values[f*VAL_W +: VAL_W] != shadow[f]);
    end

    // Round-robin pick of the first pending field at or after rr.
    always_comb begin
        pick     = '0;
        any_pend = 1'b0;
        for (int o = NUM_FIELDS - 1; o >= 0; o--) begin
            if (pend[rr_idx(rr, o)]) begin
                pick     = rr_idx(rr, o);
                any_pend = 1'b1;
            end
        end
    end

    // Per-field muxes for the field being serviced, plus digit rendering.
    always_comb begin
        cur_val    = '0;
        field_base = '0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (sel == FW'(f)) begin
                cur_val    = values[f*VAL_W +: VAL_W];
                field_base = FIELD_BASE[f*ADDR_W +: ADDR_W];
            end
        end
        nib = '0;
        for (int d = 0; d < DIGITS; d++)
            if (k == KW'(DIGITS - 1 - d)) nib = bcd[d*4 +: 4];
        last_digit = (k == KW'(DIGITS - 1));
        blank      = BLANK_LZ && !seen_nz && (nib == 4'd0) && !last_digit;
        digit_char = blank ? 8'h20 : {4'h3, nib};
        fmt_addr   = field_base + ADDR_W'(k);
    end

    // Double-dabble correction: bump every nibble >= 5 by 3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < DIGITS; d++)
            if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end

    // Write-port arbitration: the host always wins, the formatter retries.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = write_address;
        wr_data = data_In;
        if (we) begin
            wr_en = 1'b1;
        end else if (state == WRITE) begin
            wr_en   = 1'b1;
            wr_addr = fmt_addr;
            wr_data = digit_char;
        end
    end

    // Character array; never cleared by Reset, out-of-range writes dropped.
    always_ff @(posedge Clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) mem[wr_addr] <= wr_data;
    end

    // Registered read port; read-during-write returns the old cell.
    always_ff @(posedge Clk) begin
        if (Reset)                              data_Out <= 8'h00;
        else if (int'(read_address) < DEPTH)    data_Out <= mem[read_address];
        else                                    data_Out <= 8'h00;
    end

    // Change tracking: shadow captures on LOAD, dirty sticks until then.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dirty  <= '1;
            shadow <= '0;
        end else begin
            for (int f = 0; f < NUM_FIELDS; f++) begin
                if (state == LOAD && sel == FW'(f)) begin
                    dirty[f]  <= 1'b0;
                    shadow[f] <= values[f*VAL_W +: VAL_W];
                end else if (pend[f]) begin
                    dirty[f] <= 1'b1;
                end
            end
        end
    end

    // Formatter state register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Formatter next state and status outputs.
    always_comb begin
        state_nx    = state;
        busy        = (state != IDLE);
        update_done = 1'b0;
        case (state)
            IDLE:    if (any_pend) state_nx = LOAD;
            LOAD:    state_nx = CONVERT;
            CONVERT: if (cnt == CW'(VAL_W - 1)) state_nx = WRITE;
            WRITE: begin
                if (!we && last_digit) begin
                    state_nx    = IDLE;
                    update_done = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Formatter datapath: field select, saturation, shift-add-3, digit index.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel     <= '0;
            rr      <= '0;
            bin     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            k       <= '0;
            seen_nz <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_pend) sel <= pick;
                LOAD: begin
                    bin     <= (int'(cur_val) > MAX_VAL) ? SAT_VAL : cur_val;
                    bcd     <= '0;
                    cnt     <= '0;
                    k       <= '0;
                    seen_nz <= 1'b0;
                    rr      <= (sel == FW'(NUM_FIELDS - 1)) ? '0 : sel + 1'b1;
                end
                CONVERT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt + 1'b1;
                end
                WRITE: begin
                    if (!we) begin
                        if (!last_digit)   k       <= k + 1'b1;
                        if (nib != 4'd0)   seen_nz <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hud_text_ram.sv
// Bench for hud_text_ram: a cycle-level behavioural model (decimal arithmetic,
// job counters) checked every cycle, plus directed literal expectations.
module tb_hud_text_ram;
    localparam int DEPTH = 160, ADDR_W = 8, NF = 2, VAL_W = 10, DIGITS = 3;
    localparam int BASE0 = 7, BASE1 = 32;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [NF*VAL_W-1:0] values, values_b;
    logic [7:0]        data_In, data_Out, dout_b;
    logic [ADDR_W-1:0] write_address, read_address, ra_b;
    logic              we, busy, update_done, busy_b, upd_b;
    logic              we_b = 1'b0;
    logic [7:0]        din_b = 8'h00;
    logic [ADDR_W-1:0] wa_b = '0;

    always #5 Clk = ~Clk;

    hud_text_ram dut (
        .Clk(Clk), .Reset(Reset), .values(values), .data_In(data_In),
        .write_address(write_address), .we(we), .read_address(read_address),
        .data_Out(data_Out), .busy(busy), .update_done(update_done));

    hud_text_ram #(.BLANK_LZ(1'b1)) dut_b (
        .Clk(Clk), .Reset(Reset), .values(values_b), .data_In(din_b),
        .write_address(wa_b), .we(we_b), .read_address(ra_b),
        .data_Out(dout_b), .busy(busy_b), .update_done(upd_b));

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_dout;
    bit         m_act, m_valid = 1'b0;
    int         m_cnt, m_k, m_f, m_rr;
    bit         m_dirty [NF];
    int         m_shadow [NF];
    logic [7:0] m_dig [DIGITS];
    int         cyc = 0;
    int         pulse_q [$];
    int         busy_cycles = 0;

    function automatic int field_base(input int f);
        return (f == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int field_val(input int f);
        return (f == 0) ? int'(values[VAL_W-1:0]) : int'(values[2*VAL_W-1:VAL_W]);
    endfunction

    initial begin
        for (int a = 0; a < DEPTH; a++) m_mem[a] = 8'h00;
        for (int d = 0; d < DIGITS; d++) begin
            m_mem[BASE0 + d] = 8'h30;
            m_mem[BASE1 + d] = 8'h30;
        end
    end

    always @(posedge Clk) begin
        bit   pend [NF];
        bit   found;
        int   idx, sel, v, tmp;
        logic [7:0] rd;
        cyc++;
        rd = (int'(read_address) < DEPTH) ? m_mem[read_address] : 8'h00;
        for (int i = 0; i < NF; i++) pend[i] = m_dirty[i] || (field_val(i) != m_shadow[i]);
        if (Reset) begin
            m_valid = 1'b1;
            m_dout  = 8'h00;
            m_act   = 1'b0;
            m_rr    = 0;
            for (int i = 0; i < NF; i++) begin m_dirty[i] = 1'b1; m_shadow[i] = 0; end
        end else begin
            m_dout = rd;
            for (int i = 0; i < NF; i++) m_dirty[i] = pend[i];
            if (!m_act) begin
                found = 1'b0; sel = 0;
                for (int o = 0; o < NF; o++) begin
                    idx = (m_rr + o) % NF;
                    if (!found && pend[idx]) begin found = 1'b1; sel = idx; end
                end
                if (found) begin m_act = 1'b1; m_cnt = 0; m_f = sel; end
            end else if (m_cnt == 0) begin
                v = field_val(m_f);
                m_shadow[m_f] = v;
                m_dirty[m_f]  = 1'b0;
                tmp = (v > 999) ? 999 : v;
                for (int d = DIGITS - 1; d >= 0; d--) begin
                    m_dig[d] = 8'h30 + 8'(tmp % 10);
                    tmp = tmp / 10;
                end
                m_k  = 0;
                m_rr = (m_f + 1) % NF;
                m_cnt = 1;
            end else if (m_cnt <= VAL_W) begin
                m_cnt++;
            end else if (!we) begin
                m_mem[field_base(m_f) + m_k] = m_dig[m_k];
                if (m_k == DIGITS - 1) m_act = 1'b0;
                else m_k++;
            end
        end
        if (we && int'(write_address) < DEPTH) m_mem[write_address] = data_In;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (m_valid) begin
            check("data_Out", data_Out, m_dout);
            check("busy", busy, m_act);
            check("update_done", update_done, m_act && m_cnt > VAL_W && m_k == DIGITS - 1 && !we);
            if (update_done) pulse_q.push_back(cyc);
            if (busy) busy_cycles++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic rd_check(input string name, input int addr, input logic [7:0] exp);
        read_address = ADDR_W'(addr);
        tick();
        check(name, data_Out, exp);
    endtask

    task automatic rd_check_b(input string name, input int addr, input logic [7:0] exp);
        ra_b = ADDR_W'(addr);
        tick();
        check(name, dout_b, exp);
    endtask

    task automatic host_write(input int addr, input logic [7:0] d);
        write_address = ADDR_W'(addr);
        data_In = d;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    function automatic int q_at(input int i);
        return (pulse_q.size() > i) ? pulse_q[i] : -1;
    endfunction

    string label = "Score:";
    int    c0;

    initial begin
        Reset = 1'b1; values = '0; values_b = '0; we = 1'b0;
        write_address = '0; data_In = 8'h00; read_address = '0; ra_b = '0;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_update_done", update_done, 1'b0);
        check("rst_data_Out", data_Out, 8'h00);

        // Initial refresh: field0 LOAD in cycle 1, done at 14; field1 LOAD at 16, done at 29.
        values   = {10'd2, 10'd0};
        values_b = {10'd0, 10'd7};
        pulse_q.delete(); busy_cycles = 0;
        Reset = 1'b0; c0 = cyc;
        repeat (40) tick();
        check("t1_pulse_count", pulse_q.size(), 2);
        check("t1_pulse0_cycle", q_at(0) - c0, 14);
        check("t1_pulse1_cycle", q_at(1) - c0, 29);
        check("t1_busy_cycles", busy_cycles, 28);
        rd_check("t1_mem7", 7, 8'h30);
        rd_check("t1_mem8", 8, 8'h30);
        rd_check("t1_mem9", 9, 8'h30);
        rd_check("t1_mem32", 32, 8'h30);
        rd_check("t1_mem33", 33, 8'h30);
        rd_check("t1_mem34", 34, 8'h32);
        rd_check_b("blz7_mem7", 7, 8'h20);
        rd_check_b("blz7_mem8", 8, 8'h20);
        rd_check_b("blz7_mem9", 9, 8'h37);
        rd_check_b("blz0_mem32", 32, 8'h20);
        rd_check_b("blz0_mem34", 34, 8'h30);

        // 345 from idle: last digit lands on the edge 14 cycles after the change is sampled;
        // a read in that same edge still sees the old cell.
        pulse_q.delete(); busy_cycles = 0;
        values[VAL_W-1:0] = 10'd345; c0 = cyc;
        repeat (13) tick();
        read_address = ADDR_W'(9);
        tick(); check("t2_mem9_before", data_Out, 8'h30);
        tick(); check("t2_mem9_same_edge", data_Out, 8'h30);
        tick(); check("t2_mem9_after", data_Out, 8'h35);
        repeat (4) tick();
        check("t2_pulse_cycle", q_at(0) - c0, 14);
        check("t2_busy_cycles", busy_cycles, 14);
        rd_check("t2_mem7", 7, 8'h33);
        rd_check("t2_mem8", 8, 8'h34);

        // Saturation above 999.
        values[VAL_W-1:0] = 10'd1023;
        repeat (20) tick();
        rd_check("t3_mem7", 7, 8'h39);
        rd_check("t3_mem8", 8, 8'h39);
        rd_check("t3_mem9", 9, 8'h39);

        // Blanked leading zeros, last digit kept.
        values_b[VAL_W-1:0] = 10'd0;
        repeat (20) tick();
        rd_check_b("blz_zero_mem7", 7, 8'h20);
        rd_check_b("blz_zero_mem8", 8, 8'h20);
        rd_check_b("blz_zero_mem9", 9, 8'h30);

        // Host label and out-of-range accesses.
        for (int i = 0; i < 6; i++) host_write(i, label[i]);
        host_write(200, 8'h55);
        for (int i = 0; i < 6; i++) rd_check("label", i, label[i]);
        rd_check("oor_read", 200, 8'h00);
        rd_check("last_cell", DEPTH - 1, 8'h00);

        // Host write collides with the formatter's write of address 8 -> one stall.
        pulse_q.delete(); busy_cycles = 0;
        values[VAL_W-1:0] = 10'd123; c0 = cyc;
        repeat (13) tick();
        host_write(8, 8'h41);
        repeat (10) tick();
        check("t5_pulse_cycle", q_at(0) - c0, 15);
        check("t5_busy_cycles", busy_cycles, 15);
        rd_check("t5_mem7", 7, 8'h31);
        rd_check("t5_mem8", 8, 8'h32);
        rd_check("t5_mem9", 9, 8'h33);

        // Reset in the middle of CONVERT.
        read_address = ADDR_W'(0);
        values = {10'd789, 10'd456};
        repeat (6) tick();
        check("t6_busy_before", busy, 1'b1);
        check("t6_dout_before", data_Out, 8'h53);
        Reset = 1'b1;
        tick();
        check("t6_busy_in_reset", busy, 1'b0);
        check("t6_dout_in_reset", data_Out, 8'h00);
        Reset = 1'b0;
        repeat (40) tick();
        rd_check("t6_mem7", 7, 8'h34);
        rd_check("t6_mem8", 8, 8'h35);
        rd_check("t6_mem9", 9, 8'h36);
        rd_check("t6_mem32", 32, 8'h37);
        rd_check("t6_mem33", 33, 8'h38);
        rd_check("t6_mem34", 34, 8'h39);
        for (int i = 0; i < 6; i++) rd_check("t6_label", i, label[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
